// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: FSM state encoding,
// condition-code bit positions and the default datapath width.
package calc_pkg;

  localparam int DEF_N = 8;

  localparam int CC_OV   = 3;
  localparam int CC_C    = 2;
  localparam int CC_NEG  = 1;
  localparam int CC_ZERO = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    SETTLE,
    CAPTURE,
    RESP
  } state_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Request/response handshake and datapath control bus of the calculator sequencer.
// slave = sequencer side, master = requester/datapath side.
interface calc_sequencer_if
  import calc_pkg::*;
#(
  parameter int N = DEF_N
) ();

  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         req_sub;
  logic         abort;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_r;
  logic [3:0]   rsp_cc;
  logic [N-1:0] dp_data;
  logic         dp_load_a;
  logic         dp_load_b;
  logic         dp_clear;
  logic         dp_addsub;
  logic [N-1:0] dp_r;
  logic         dp_cout;
  logic         dp_ovf;
  logic         dp_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, abort, rsp_ready,
           dp_r, dp_cout, dp_ovf, dp_zero,
    output req_ready, rsp_valid, rsp_r, rsp_cc,
           dp_data, dp_load_a, dp_load_b, dp_clear, dp_addsub
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, abort, rsp_ready,
           dp_r, dp_cout, dp_ovf, dp_zero,
    input  req_ready, rsp_valid, rsp_r, rsp_cc,
           dp_data, dp_load_a, dp_load_b, dp_clear, dp_addsub
  );

endinterface

// File: rtl/calc_settle_timer.sv
// 4-bit down-counter that times the ripple-carry settle window.
// Loads a start value, counts down while enabled, flags done at zero.
module calc_settle_timer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       i_load,
  input  logic [3:0] i_val,
  input  logic       i_en,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/calc_sequencer.sv
// Transaction controller for the 8-bit add/subtract calculator datapath.
// Optional result saturation on signed overflow: define CALC_SEQ_SATURATE_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int SETTLE_CYC = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  calc_sequencer_if.slave  bus
);

`ifdef CALC_SEQ_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam logic [3:0]   SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [N-1:0] SAT_MAX   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN   = {1'b1, {(N-1){1'b0}}};

  // A wrapped positive overflow shows a set sign bit, a wrapped negative one a clear sign bit.
  function automatic logic [N-1:0] sat_result(input logic [N-1:0] r, input logic ovf,
                                              input logic en);
    if (en && ovf) return r[N-1] ? SAT_MAX : SAT_MIN;
    return r;
  endfunction

  state_t       r_state;
  logic         r_req_ready;
  logic         r_rsp_valid;
  logic [N-1:0] r_rsp_r;
  logic [3:0]   r_rsp_cc;
  logic [N-1:0] r_dp_data;
  logic         r_dp_load_a;
  logic         r_dp_load_b;
  logic         r_dp_clear;
  logic         r_dp_addsub;
  logic [N-1:0] r_b;

  logic [N-1:0] w_res;
  logic [3:0]   w_cc;
  logic         w_tmr_done;

  calc_settle_timer u_timer (
    .CLK    (CLK),
    .CLR    (CLR),
    .i_load (r_state == LOAD_B),
    .i_val  (SETTLE_LD),
    .i_en   (r_state == SETTLE),
    .o_done (w_tmr_done)
  );

  assign w_res = sat_result(bus.dp_r, bus.dp_ovf, SAT_EN);

  always_comb begin
    w_cc           = 4'd0;
    w_cc[CC_OV]    = bus.dp_ovf;
    w_cc[CC_C]     = bus.dp_cout;
    w_cc[CC_NEG]   = w_res[N-1];
    w_cc[CC_ZERO]  = SAT_EN ? (w_res == '0) : bus.dp_zero;
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_cc    <= 4'd0;
      r_dp_data   <= '0;
      r_dp_load_a <= 1'b0;
      r_dp_load_b <= 1'b0;
      r_dp_clear  <= 1'b1;
      r_dp_addsub <= 1'b0;
    end else begin
      r_dp_load_a <= 1'b0;
      r_dp_load_b <= 1'b0;
      r_dp_clear  <= 1'b0;
      // Abort outranks everything, including a pending request or response handshake.
      if (bus.abort) begin
        r_state     <= IDLE;
        r_rsp_valid <= 1'b0;
        r_dp_clear  <= 1'b1;
        r_req_ready <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.req_valid && r_req_ready) begin
              r_b         <= bus.req_b;
              r_dp_data   <= bus.req_a;
              r_dp_addsub <= bus.req_sub;
              r_dp_load_a <= 1'b1;
              r_req_ready <= 1'b0;
              r_state     <= LOAD_A;
            end else begin
              r_req_ready <= 1'b1;
            end
          end
          LOAD_A: begin
            r_dp_data   <= r_b;
            r_dp_load_b <= 1'b1;
            r_state     <= LOAD_B;
          end
          LOAD_B: r_state <= SETTLE;
          SETTLE: begin
            if (w_tmr_done) r_state <= CAPTURE;
          end
          CAPTURE: begin
            r_rsp_r     <= w_res;
            r_rsp_cc    <= w_cc;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
          RESP: begin
            if (bus.rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_r     = r_rsp_r;
  assign bus.rsp_cc    = r_rsp_cc;
  assign bus.dp_data   = r_dp_data;
  assign bus.dp_load_a = r_dp_load_a;
  assign bus.dp_load_b = r_dp_load_b;
  assign bus.dp_clear  = r_dp_clear;
  assign bus.dp_addsub = r_dp_addsub;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Transaction-level controller for the 8-bit add/subtract calculator datapath (operand registers A/B, ripple-carry add/sub, overflow/zero flags).
- Accepts one operation request at a time over a valid/ready handshake and drives the operand bus and register-load strobes in order.
- Waits for the ripple chain to settle, then captures the result and the condition codes into output registers.
- Returns the result and condition codes over a valid/ready response handshake. Replaces manual push-button sequencing of InA/InB/Out.

Parameters:
- N, 8, datapath width in bits.
- SETTLE_CYC, 2, cycles held in SETTLE before capture (1..15).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- CLR  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  N  operand A.
- req_b  input  N  operand B.
- req_sub  input  1  1 = A-B, 0 = A+B.
- abort  input  1  cancel the in-flight operation.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_r  output  N  result.
- rsp_cc  output  4  condition codes {OV,C,NEG,ZERO}.
- dp_data  output  N  operand bus to datapath registers.
- dp_load_a  output  1  one-cycle load strobe, register A.
- dp_load_b  output  1  one-cycle load strobe, register B.
- dp_clear  output  1  datapath register clear.
- dp_addsub  output  1  add/subtract select to datapath.
- dp_r  input  N  datapath sum/difference.
- dp_cout  input  1  datapath carry out.
- dp_ovf  input  1  datapath signed overflow.
- dp_zero  input  1  datapath result-zero flag.

Behaviour:
- All outputs are registered.
- Reset (CLR=0 sampled at an edge):
  - state=IDLE.
  - req_ready=0, rsp_valid=0, rsp_r=0, rsp_cc=0, dp_data=0, dp_load_a=0, dp_load_b=0, dp_addsub=0.
  - dp_clear=1.
- dp_clear deasserts on the first edge after CLR returns high. req_ready rises on the same edge.
- States: IDLE, LOAD_A, LOAD_B, SETTLE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a, req_b, req_sub internally; req_ready->0; go to LOAD_A.
- LOAD_A: dp_data=latched A, dp_load_a=1 for exactly this cycle, dp_addsub=latched sub; go to LOAD_B.
- LOAD_B: dp_data=latched B, dp_load_b=1 for exactly this cycle; go to SETTLE and load the settle counter with SETTLE_CYC-1.
- SETTLE:
  - dp_addsub held.
  - Counter decrements each cycle; at 0 go to CAPTURE.
- CAPTURE:
  - Register rsp_r=dp_r.
  - Register rsp_cc = {dp_ovf, dp_cout, dp_r[N-1], dp_zero}.
  - Go to RESP with rsp_valid=1.
- RESP:
  - rsp_valid, rsp_r and rsp_cc hold stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid->0, go to IDLE, req_ready->1 on the next cycle.
  - No back-to-back acceptance in the handoff cycle.
- Latency: request accept edge to rsp_valid high = 3+SETTLE_CYC cycles (5 at default).
- C is the raw adder carry. For subtract, C=1 means no borrow. No inversion is applied.
- dp_load_a and dp_load_b are never high in the same cycle. Each is never high outside its state.
- abort (any state except IDLE):
  - Next state is IDLE.
  - rsp_valid->0; rsp_r/rsp_cc keep their last values.
  - dp_clear=1 for exactly one cycle.
  - req_ready stays 0 during the dp_clear cycle.
- abort in IDLE: dp_clear pulses once; a concurrent req_valid is not accepted (req_ready=0 that cycle).
- abort and rsp_ready in the same RESP cycle: abort wins. The result is dropped and no handshake completes.
- Request inputs are ignored outside IDLE. Operands are sampled only at acceptance.
- Reset mid-operation: immediate return to the reset state, identical to power-up.

Optional Feature:
- Macro: CALC_SEQ_SATURATE_EN.
- Defined: in CAPTURE, if dp_ovf=1, rsp_r saturates. Positive overflow (dp_r[N-1]=1) gives 2^(N-1)-1 (0x7F). Negative overflow (dp_r[N-1]=0) gives 2^(N-1) (0x80).
- Defined: rsp_cc OV stays 1; NEG and ZERO are recomputed from the saturated value.
- Undefined: rsp_r=dp_r unconditionally (wrap-around).

Decomposition:
- Package calc_pkg:
  - State enum type.
  - CC bit-index constants CC_OV=3, CC_C=2, CC_NEG=1, CC_ZERO=0.
  - Default width constant 8.
- One sub-module, calc_settle_timer: 4-bit down-counter with load/done, used by SETTLE.

Test Plan:
- Add, no flags: A=0x05, B=0x03, sub=0, rsp_ready=1 -> rsp_valid 5 cycles after accept; rsp_r=0x08, rsp_cc=4'b0000.
- Signed overflow: A=0x7F, B=0x01, add -> rsp_r=0x80, rsp_cc=4'b1010. With CALC_SEQ_SATURATE_EN -> rsp_r=0x7F, rsp_cc=4'b1000.
- Subtract to zero: A=0x05, B=0x05, sub=1 -> rsp_r=0x00, rsp_cc=4'b0101. Also A=0x03, B=0x05, sub=1 -> rsp_r=0xFE, rsp_cc=4'b0010.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_r, rsp_cc stable and req_ready=0 throughout. The new request is taken only one cycle after the handshake.
- Abort in SETTLE -> single dp_clear pulse, rsp_valid never asserts, back to IDLE. abort with rsp_ready in RESP -> no handshake.
- Strobe checks: dp_load_a is high for one cycle with dp_data=A, then dp_load_b for one cycle with dp_data=B. CLR=0 mid-LOAD_B -> all outputs at reset values on the next edge, with dp_clear=1.
